// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register decoder.
package spi_reg_pkg;

    localparam int NUM_REGS_DEFAULT = 5;

    // Register bank address map
    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_PWM_DUTY  = 4;

    // Command byte bit7 value meaning "write"
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sync_nff.sv
// N-flop single-bit synchroniser with a configurable reset value.
module sync_nff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= {STAGES{RST_VAL}};
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_reg_decoder.sv
// Two-byte SPI frame decoder: syncs rx strobe / chip-select into clk and
// maintains the control register bank plus read-back to the tx path.
module spi_reg_decoder
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS    = NUM_REGS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       cs_n,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [7:0] en_out_lo,
    output logic [7:0] en_out_hi,
    output logic [7:0] en_pwm_lo,
    output logic [7:0] en_pwm_hi,
    output logic [7:0] pwm_duty,
    output logic       frame_err
);

    logic       rx_done_s, cs_n_s, rx_done_d, byte_evt;
    logic       rw_q;
    logic [6:0] addr_q;
    logic [7:0] regs [NUM_REGS];
    state_t     state_q, state_d;

    // Combinational decisions from the FSM
    logic       hdr_ld, wr_en, err_set, tx_clr, addr_ok;
    logic [7:0] rd_val;

    sync_nff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rx (
        .clk(clk), .rst_n(rst_n), .d(rx_done), .q(rx_done_s)
    );

    sync_nff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s)
    );

    // Registered rising-edge detect: rx_done may sit high across frame gaps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_d <= 1'b0;
            byte_evt  <= 1'b0;
        end else begin
            rx_done_d <= rx_done_s;
            byte_evt  <= rx_done_s & ~rx_done_d;
        end
    end

    // Read mux over the incoming address byte; out-of-range reads return 0
    always_comb begin
        rd_val = 8'h00;
        for (int i = 0; i < NUM_REGS; i++)
            if (rx_data[6:0] == 7'(i)) rd_val = regs[i];
    end

    assign addr_ok = (32'(addr_q) < NUM_REGS);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath strobes; cs_n release overrides after the byte
    always_comb begin
        state_d = state_q;
        hdr_ld  = 1'b0;
        wr_en   = 1'b0;
        err_set = 1'b0;
        tx_clr  = 1'b0;
        case (state_q)
            ST_IDLE: if (byte_evt && !cs_n_s) begin
                hdr_ld  = 1'b1;
                state_d = ST_DATA;
            end
            ST_DATA: if (byte_evt) begin
                if (rw_q == RW_WRITE) begin
                    if (addr_ok) wr_en   = 1'b1;
                    else         err_set = 1'b1;
                end
                state_d = ST_DONE;
            end
            default: ;
        endcase
        if (cs_n_s) begin
            state_d = ST_IDLE;
            tx_clr  = 1'b1;
        end
    end

    // Frame header, read-back path and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q      <= 1'b0;
            addr_q    <= '0;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_set;
            if (hdr_ld) begin
                rw_q   <= rx_data[7];
                addr_q <= rx_data[6:0];
                if (rx_data[7] != RW_WRITE) begin
                    tx_data  <= rd_val;
                    tx_start <= 1'b1;
                end
            end
            if (tx_clr) tx_start <= 1'b0;
        end
    end

    // Register bank write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (addr_q == 7'(i)) regs[i] <= rx_data;
        end
    end

    assign en_out_lo = regs[ADDR_EN_OUT_LO];
    assign en_out_hi = regs[ADDR_EN_OUT_HI];
    assign en_pwm_lo = regs[ADDR_EN_PWM_LO];
    assign en_pwm_hi = regs[ADDR_EN_PWM_HI];
    assign pwm_duty  = regs[ADDR_PWM_DUTY];

endmodule

// File: tb/tb_spi_reg_decoder.sv
// Directed bench for spi_reg_decoder: two-byte frames, read-back, errors, reset.
module tb_spi_reg_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       cs_n;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, pwm_duty;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;

    spi_reg_decoder dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .cs_n(cs_n), .tx_data(tx_data), .tx_start(tx_start),
        .en_out_lo(en_out_lo), .en_out_hi(en_out_hi), .en_pwm_lo(en_pwm_lo),
        .en_pwm_hi(en_pwm_hi), .pwm_duty(pwm_duty), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count frame_err cycles
    always @(posedge clk) if (frame_err === 1'b1) err_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SPI byte: rx_done high 8 clks, low 8 clks
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick(8);
        rx_done = 1'b0;
        tick(8);
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; cs_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        n_cmp++;
        if ({en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, pwm_duty} !== 40'h0) begin
            n_bad++; $display("FAIL reset_regs got %h exp 0", {en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, pwm_duty});
        end
        n_cmp++;
        if ({tx_data, tx_start, frame_err} !== 10'h0) begin
            n_bad++; $display("FAIL reset_tx got %h exp 0", {tx_data, tx_start, frame_err});
        end
    endtask

    task automatic test_write();
        frame_start();
        send_byte(8'h84);
        rx_data = 8'hA5;
        rx_done = 1'b1;
        tick(3);
        n_cmp++;
        if (pwm_duty !== 8'h00) begin
            n_bad++; $display("FAIL write_early got %h exp 00", pwm_duty);
        end
        tick(1);
        n_cmp++;
        if (pwm_duty !== 8'hA5) begin
            n_bad++; $display("FAIL write_latency got %h exp a5", pwm_duty);
        end
        tick(4);
        rx_done = 1'b0;
        tick(8);
        frame_end();
        n_cmp++;
        if ({en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi} !== 32'h0) begin
            n_bad++; $display("FAIL write_others got %h exp 0", {en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi});
        end
    endtask

    task automatic test_read();
        frame_start(); send_byte(8'h81); send_byte(8'hFF); frame_end();
        frame_start();
        send_byte(8'h01);
        n_cmp++;
        if (tx_data !== 8'hFF || tx_start !== 1'b1) begin
            n_bad++; $display("FAIL read_data got %h/%b exp ff/1", tx_data, tx_start);
        end
        send_byte(8'h00);
        n_cmp++;
        if (en_out_hi !== 8'hFF) begin
            n_bad++; $display("FAIL read_no_write got %h exp ff", en_out_hi);
        end
        frame_end();
        n_cmp++;
        if (tx_start !== 1'b0 || tx_data !== 8'hFF) begin
            n_bad++; $display("FAIL read_cs_release got %h/%b exp ff/0", tx_data, tx_start);
        end
    endtask

    task automatic test_bad_addr();
        err_cnt = 0;
        frame_start(); send_byte(8'h90); send_byte(8'h33); frame_end();
        n_cmp++;
        if (err_cnt !== 1) begin
            n_bad++; $display("FAIL err_pulse got %0d exp 1", err_cnt);
        end
        n_cmp++;
        if ({en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, pwm_duty} !== 40'h00FF0000A5) begin
            n_bad++; $display("FAIL err_regs got %h exp 00ff0000a5", {en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, pwm_duty});
        end
        frame_start(); send_byte(8'h10);
        n_cmp++;
        if (tx_data !== 8'h00 || tx_start !== 1'b1) begin
            n_bad++; $display("FAIL read_oob got %h/%b exp 00/1", tx_data, tx_start);
        end
        frame_end();
    endtask

    task automatic test_extra_byte();
        frame_start(); send_byte(8'h82); send_byte(8'h11); send_byte(8'h22);
        n_cmp++;
        if (en_pwm_lo !== 8'h11) begin
            n_bad++; $display("FAIL extra_byte got %h exp 11", en_pwm_lo);
        end
        frame_end();
        frame_start(); send_byte(8'h82); send_byte(8'h44); frame_end();
        n_cmp++;
        if (en_pwm_lo !== 8'h44) begin
            n_bad++; $display("FAIL next_frame got %h exp 44", en_pwm_lo);
        end
    endtask

    task automatic test_back_to_back();
        frame_start();
        send_byte(8'h83);
        rx_data = 8'h77;
        rx_done = 1'b1;
        tick(8);
        cs_n = 1'b1;           // rx_done stays high across the gap
        tick(6);
        rx_data = 8'h03;
        cs_n = 1'b0;
        tick(6);
        n_cmp++;
        if (en_pwm_hi !== 8'h77 || tx_start !== 1'b0) begin
            n_bad++; $display("FAIL held_rx got %h/%b exp 77/0", en_pwm_hi, tx_start);
        end
        rx_done = 1'b0;
        tick(8);
        send_byte(8'h03);
        n_cmp++;
        if (tx_data !== 8'h77 || tx_start !== 1'b1) begin
            n_bad++; $display("FAIL held_rx_read got %h/%b exp 77/1", tx_data, tx_start);
        end
        send_byte(8'h99);
        frame_end();
        n_cmp++;
        if (en_pwm_hi !== 8'h77 || en_out_hi !== 8'hFF) begin
            n_bad++; $display("FAIL held_rx_nowr got %h/%h exp 77/ff", en_pwm_hi, en_out_hi);
        end
    endtask

    task automatic test_reset_mid_frame();
        frame_start();
        send_byte(8'h80);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({en_pwm_hi, en_out_hi, pwm_duty, tx_data, tx_start} !== 33'h0) begin
            n_bad++; $display("FAIL async_reset got %h exp 0", {en_pwm_hi, en_out_hi, pwm_duty, tx_data, tx_start});
        end
        tick(2);
        rst_n = 1'b1;
        tick(4);
        send_byte(8'h83);
        send_byte(8'h5A);
        frame_end();
        n_cmp++;
        if (en_pwm_hi !== 8'h5A || en_out_lo !== 8'h00) begin
            n_bad++; $display("FAIL post_reset got %h/%h exp 5a/00", en_pwm_hi, en_out_lo);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_extra_byte();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
